reg_file: RTL

- Architectural register file with rename-tag (register status) table for the Tomasulo core.
- It is the receiving end of the ROB commit interface: it takes committed writebacks (dest reg, data, ROB number) from the ROB.
- On the issue side it renames destinations to ROB entries and answers issue's two source-operand queries with value, busy flag and producing ROB number.
- On a ROB misbranch it drops all pending rename tags.

---
 rtl/reg_file.sv | 118 +++++++++++
 1 files changed

// File: rtl/reg_file.sv
// Architectural register file with rename-tag table for the Tomasulo core.
// Commits from the ROB write values; issue renames destinations; misbranch drops all tags.
module reg_file #(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,

    input  logic              has_misbranch,

    input  logic              has_issued,
    input  logic [4:0]        in_dest,
    input  logic [TAG_W-1:0]  in_dest_robnum,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    output logic [DATA_W-1:0] out_rs1_data,
    output logic              out_rs1_busy,
    output logic [TAG_W-1:0]  out_rs1_robnum,
    output logic [DATA_W-1:0] out_rs2_data,
    output logic              out_rs2_busy,
    output logic [TAG_W-1:0]  out_rs2_robnum,

    input  logic              has_from_rob,
    input  logic [4:0]        in_rob_dest,
    input  logic [DATA_W-1:0] in_rob_data,
    input  logic [TAG_W-1:0]  in_rob_robnum
);

    logic [DATA_W-1:0] value_q [REG_NUM];
    logic [DATA_W-1:0] value_d [REG_NUM];
    logic [TAG_W-1:0]  tag_q   [REG_NUM];
    logic [TAG_W-1:0]  tag_d   [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    logic commit_en;
    logic rename_en;

    assign commit_en = has_from_rob && (in_rob_dest != 5'd0);
    assign rename_en = has_issued && !has_misbranch && (in_dest != 5'd0);

    // Commit is applied first so a same-cycle rename of that register overrides the busy clear.
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        if (commit_en) begin
            value_d[in_rob_dest] = in_rob_data;
            if (busy_q[in_rob_dest] && (tag_q[in_rob_dest] == in_rob_robnum)) begin
                busy_d[in_rob_dest] = 1'b0;
            end
        end
        if (has_misbranch) begin
            busy_d = '0;
        end else if (rename_en) begin
            busy_d[in_dest] = 1'b1;
            tag_d[in_dest]  = in_dest_robnum;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q <= '0;
        end else if (rdy) begin
            value_q <= value_d;
            tag_q   <= tag_d;
            busy_q  <= busy_d;
        end
    end

    logic bypass1;
    logic bypass2;

    assign bypass1 = rdy && has_from_rob && (in_rob_dest == in_rs1) && (in_rs1 != 5'd0)
                     && busy_q[in_rs1] && (tag_q[in_rs1] == in_rob_robnum);
    assign bypass2 = rdy && has_from_rob && (in_rob_dest == in_rs2) && (in_rs2 != 5'd0)
                     && busy_q[in_rs2] && (tag_q[in_rs2] == in_rob_robnum);

    always_comb begin
        out_rs1_data   = '0;
        out_rs1_busy   = 1'b0;
        out_rs1_robnum = '0;
        if (in_rs1 != 5'd0) begin
            out_rs1_robnum = tag_q[in_rs1];
            if (bypass1) begin
                out_rs1_data = in_rob_data;
                out_rs1_busy = 1'b0;
            end else begin
                out_rs1_data = value_q[in_rs1];
                out_rs1_busy = busy_q[in_rs1];
            end
        end
    end

    always_comb begin
        out_rs2_data   = '0;
        out_rs2_busy   = 1'b0;
        out_rs2_robnum = '0;
        if (in_rs2 != 5'd0) begin
            out_rs2_robnum = tag_q[in_rs2];
            if (bypass2) begin
                out_rs2_data = in_rob_data;
                out_rs2_busy = 1'b0;
            end else begin
                out_rs2_data = value_q[in_rs2];
                out_rs2_busy = busy_q[in_rs2];
            end
        end
    end

endmodule
